// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants, fetch FSM state type and PC alignment helper.
package cpu_pipe_pkg;

  localparam int unsigned PC_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [PC_WIDTH-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    REDIRECT
  } fetch_state_t;

  // Instructions are word aligned; low address bits of a target are ignored.
  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] addr);
    return {addr[PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: register, +4 incrementer, aligned redirect target select and hold mux.
module fetch_pc_reg
  import cpu_pipe_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                advance_i,
  input  logic                redirect_i,
  input  logic                jump_i,
  input  logic [PC_WIDTH-1:0] jump_target_i,
  input  logic [PC_WIDTH-1:0] branch_target_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic [PC_WIDTH-1:0] pc_plus4_o
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] target;

  always_comb begin
    target     = align_pc(jump_i ? jump_target_i : branch_target_i);
    pc_plus4_o = pc_q + PC_INCR;
    pc_d       = pc_q;
    if (redirect_i) begin
      pc_d = target;
    end else if (advance_i) begin
      pc_d = pc_plus4_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch controller and IF/ID register: stall hold, flush redirect with NOP bubbles, stall watchdog.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_redirect_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FLUSH_BUBBLES = 1,
  parameter int unsigned STALL_LIMIT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_enable,
  input  logic        flush,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] fd_instruction,
  output logic [31:0] fd_pc_plus4,
  output logic        fd_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt,
`endif
  output logic        stall_timeout
);

  localparam logic [3:0] BubbleReload = 4'(FLUSH_BUBBLES - 1);
  localparam logic [7:0] StallLimitM1 = 8'(STALL_LIMIT - 1);

  fetch_state_t state_q, state_d;
  logic [3:0]   bubble_cnt_q, bubble_cnt_d;
  logic [7:0]   stall_cnt_q, stall_cnt_d;
  logic         timeout_q, timeout_d;
  logic [31:0]  fd_instr_q, fd_instr_d;
  logic [31:0]  fd_pc4_q, fd_pc4_d;
  logic         fd_valid_q, fd_valid_d;
  logic [31:0]  pc, pc_plus4;
  logic         pc_advance, stall_cycle, fetch_cycle;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk            (clk),
    .rst            (rst),
    .advance_i      (pc_advance),
    .redirect_i     (flush),
    .jump_i         (jump),
    .jump_target_i  (jump_target),
    .branch_target_i(branch_target),
    .pc_o           (pc),
    .pc_plus4_o     (pc_plus4)
  );

  always_comb begin
    state_d      = state_q;
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    timeout_d    = timeout_q;
    fd_instr_d   = fd_instr_q;
    fd_pc4_d     = fd_pc4_q;
    fd_valid_d   = fd_valid_q;
    pc_advance   = 1'b0;
    stall_cycle  = 1'b0;
    fetch_cycle  = 1'b0;
    if (flush) begin
      fd_instr_d   = NOP_INSTR;
      fd_pc4_d     = '0;
      fd_valid_d   = 1'b0;
      bubble_cnt_d = BubbleReload;
      stall_cnt_d  = '0;
      state_d      = (FLUSH_BUBBLES == 32'd1) ? RUN : REDIRECT;
    end else if (!load_enable) begin
      stall_cycle = 1'b1;
      state_d     = STALL;
      if (stall_cnt_q != 8'hFF) begin
        stall_cnt_d = stall_cnt_q + 8'd1;
      end
      if (stall_cnt_q >= StallLimitM1) begin
        timeout_d = 1'b1;
      end
    end else begin
      stall_cnt_d = '0;
      // A stall taken mid-redirect parks in STALL with bubbles still owed.
      if (state_q != RUN && bubble_cnt_q != 4'd0) begin
        bubble_cnt_d = bubble_cnt_q - 4'd1;
        state_d      = REDIRECT;
      end else begin
        fetch_cycle = 1'b1;
        pc_advance  = 1'b1;
        fd_instr_d  = imem_rdata;
        fd_pc4_d    = pc_plus4;
        fd_valid_d  = 1'b1;
        state_d     = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
      timeout_q    <= 1'b0;
      fd_instr_q   <= NOP_INSTR;
      fd_pc4_q     <= '0;
      fd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      timeout_q    <= timeout_d;
      fd_instr_q   <= fd_instr_d;
      fd_pc4_q     <= fd_pc4_d;
      fd_valid_q   <= fd_valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_stall_q;
  logic [15:0] perf_flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_q + {31'd0, fetch_cycle};
      perf_stall_q <= perf_stall_q + {31'd0, stall_cycle};
      perf_flush_q <= perf_flush_q + {15'd0, flush};
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

  assign imem_addr      = pc;
  assign fd_instruction = fd_instr_q;
  assign fd_pc_plus4    = fd_pc4_q;
  assign fd_valid       = fd_valid_q;
  assign stall_timeout  = timeout_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed plus random bench for fetch_redirect_ctrl (1-bubble and 3-bubble instances).
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst, load_enable, flush, jump;
  logic [31:0] jump_target, branch_target;

  logic [31:0] addr [2];
  logic [31:0] rdata [2];
  logic [31:0] fi [2];
  logic [31:0] fp [2];
  logic        fv [2];
  logic        to [2];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state, one slot per instance.
  int unsigned bub [2] = '{1, 3};
  logic [31:0] m_pc [2];
  logic [31:0] m_fi [2];
  logic [31:0] m_fp [2];
  logic        m_v [2];
  logic        m_to [2];
  int unsigned m_pend [2];
  int unsigned m_srun [2];

  always #5 clk = ~clk;

  assign rdata[0] = addr[0] + 32'h100;
  assign rdata[1] = addr[1] + 32'h100;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pf0, ps0, pf1, ps1;
  logic [15:0] pl0, pl1;
`endif

  fetch_redirect_ctrl #(
    .RESET_PC     (32'h0),
    .FLUSH_BUBBLES(1),
    .STALL_LIMIT  (16)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .load_enable   (load_enable),
    .flush         (flush),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_target (branch_target),
    .imem_addr     (addr[0]),
    .imem_rdata    (rdata[0]),
    .fd_instruction(fi[0]),
    .fd_pc_plus4   (fp[0]),
    .fd_valid      (fv[0]),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt(pf0),
    .perf_stall_cnt(ps0),
    .perf_flush_cnt(pl0),
`endif
    .stall_timeout (to[0])
  );

  fetch_redirect_ctrl #(
    .RESET_PC     (32'h0),
    .FLUSH_BUBBLES(3),
    .STALL_LIMIT  (16)
  ) u_dut3 (
    .clk           (clk),
    .rst           (rst),
    .load_enable   (load_enable),
    .flush         (flush),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_target (branch_target),
    .imem_addr     (addr[1]),
    .imem_rdata    (rdata[1]),
    .fd_instruction(fi[1]),
    .fd_pc_plus4   (fp[1]),
    .fd_valid      (fv[1]),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt(pf1),
    .perf_stall_cnt(ps1),
    .perf_flush_cnt(pl1),
`endif
    .stall_timeout (to[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_fi[k] = 32'h0; m_fp[k] = 32'h0; m_v[k] = 1'b0;
      m_to[k] = 1'b0; m_pend[k] = 0; m_srun[k] = 0;
    end
  endtask

  // Spec-level behaviour: flush beats stall beats fetch; owed bubbles are paid before fetching.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (flush) begin
        m_pc[k]   = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
        m_fi[k]   = 32'h0; m_fp[k] = 32'h0; m_v[k] = 1'b0;
        m_pend[k] = bub[k] - 1;
        m_srun[k] = 0;
      end else if (!load_enable) begin
        if (m_srun[k] < 255) m_srun[k]++;
        if (m_srun[k] >= 16) m_to[k] = 1'b1;
      end else begin
        m_srun[k] = 0;
        if (m_pend[k] > 0) begin
          m_pend[k]--;
        end else begin
          m_fi[k] = m_pc[k] + 32'h100;
          m_fp[k] = m_pc[k] + 32'd4;
          m_v[k]  = 1'b1;
          m_pc[k] = m_pc[k] + 32'd4;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("imem_addr[%0d]", k), addr[k], m_pc[k]);
      chk($sformatf("fd_instruction[%0d]", k), fi[k], m_fi[k]);
      chk($sformatf("fd_pc_plus4[%0d]", k), fp[k], m_fp[k]);
      chk($sformatf("fd_valid[%0d]", k), {31'd0, fv[k]}, {31'd0, m_v[k]});
      chk($sformatf("stall_timeout[%0d]", k), {31'd0, to[k]}, {31'd0, m_to[k]});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #2;
    check_all();
  endtask

  task automatic drive(input logic le, input logic fl, input logic jp,
                       input logic [31:0] jt, input logic [31:0] bt);
    load_enable = le; flush = fl; jump = jp; jump_target = jt; branch_target = bt;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    model_reset();
    cyc();
    cyc();
    rst = 1'b0;
    check_all();

    // Straight-line fetch from RESET_PC.
    cyc();
    chk("first_fetch_instr", fi[0], 32'h100);
    cyc();
    chk("second_fetch_instr", fi[0], 32'h104);
    chk("pc_before_stall", addr[0], 32'h8);

    // Three-cycle stall freezes everything.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) cyc();
    chk("stall_frozen_pc", addr[0], 32'h8);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    chk("resume_instr", fi[0], 32'h108);

    // Branch redirect with misaligned target.
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h203);
    cyc();
    chk("branch_pc", addr[0], 32'h200);
    chk("branch_bubble_valid", {31'd0, fv[0]}, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    chk("branch_first_instr", fi[0], 32'h300);
    repeat (3) cyc();

    // Flush beats a simultaneous stall.
    drive(1'b0, 1'b1, 1'b1, 32'h40, 32'h0);
    cyc();
    chk("jump_over_stall_pc", addr[0], 32'h40);
    chk("jump_over_stall_pc3", addr[1], 32'h40);

    // Three bubbles with a stall during the second one.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    cyc();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    chk("third_bubble_valid", {31'd0, fv[1]}, 32'h0);
    cyc();
    chk("post_bubble_instr", fi[1], 32'h140);

    // Re-flush inside REDIRECT restarts the bubble count at the new target.
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h80);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    drive(1'b1, 1'b1, 1'b1, 32'h1000, 32'h0);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    cyc();
    chk("reflush_still_bubble", {31'd0, fv[1]}, 32'h0);
    cyc();
    chk("reflush_instr", fi[1], 32'h1100);

    // PC wrap at the top of the address space.
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0);
    cyc();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    chk("wrap_pc", addr[0], 32'h0);
    chk("wrap_pc_plus4", fp[0], 32'h0);
    repeat (3) cyc();

    // Stall watchdog: rises on stall cycle 16, sticky afterwards.
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      cyc();
      chk($sformatf("timeout_cycle_%0d", i), {31'd0, to[0]}, (i >= 16) ? 32'd1 : 32'd0);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) cyc();
    chk("timeout_sticky", {31'd0, to[0]}, 32'd1);

    // Asynchronous reset in the middle of a stall.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) cyc();
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_timeout", {31'd0, to[0]}, 32'd0);
    chk("async_rst_valid", {31'd0, fv[0]}, 32'd0);
    check_all();
    cyc();
    #2;
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
            $urandom, $urandom);
      if (n % 100 == 50) begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (18) cyc();
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Fetch-stage controller and IF/ID pipeline register. It consumes the stall request (load_enable) and the flush request from the hazard detection logic.
- Owns the PC, drives the instruction-memory address, and applies redirects from jump and taken-branch resolution.
- Inserts NOP bubbles into IF/ID. Sits between instruction memory and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_BUBBLES, 1, number of NOP cycles inserted per redirect. Legal range 1..15.
- STALL_LIMIT, 16, consecutive stall cycles before stall_timeout sets. Legal range 2..255.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset
- load_enable  in  1  0 = hold PC and IF/ID (stall)
- flush  in  1  1 = discard the IF/ID contents and redirect
- jump  in  1  redirect source select: 1 = jump_target
- jump_target  in  32  jump destination
- branch_target  in  32  taken-branch destination, used when flush=1 and jump=0
- imem_addr  out  32  instruction-memory address, equal to pc
- imem_rdata  in  32  instruction word, combinational from imem_addr
- fd_instruction  out  32  IF/ID instruction (32'h0 = NOP)
- fd_pc_plus4  out  32  IF/ID PC+4
- fd_valid  out  1  IF/ID holds a real instruction
- stall_timeout  out  1  sticky: stall exceeded STALL_LIMIT

Behaviour:
- Reset: rst is asynchronous, active-high. While rst=1 and on release:
  - pc=RESET_PC
  - fd_instruction=0, fd_pc_plus4=0, fd_valid=0
  - stall_timeout=0, stall_cnt=0, bubble_cnt=0
  - state=RUN
- Reset mid-operation abandons any redirect or stall immediately.
- States:
  - RUN: normal fetch.
  - STALL: holding.
  - REDIRECT: emitting bubbles after a flush.
- Priority each cycle: flush > stall (load_enable=0) > normal fetch. When flush=1 and load_enable=0 together, the flush wins and the stall is ignored.
- RUN, normal fetch:
  - fd_instruction <= imem_rdata
  - fd_pc_plus4 <= pc+4
  - fd_valid <= 1
  - pc <= pc+4
- Latency: an instruction appears on fd_* one cycle after pc addresses it.
- Stall (any state except on a flush cycle): pc and all fd_* hold; state -> STALL; stall_cnt increments, saturating at 255. When load_enable returns to 1: stall_cnt clears, normal fetch resumes the same cycle, state -> RUN.
- stall_timeout: sets when stall_cnt reaches STALL_LIMIT-1 while still stalled. It clears only on rst.
- Flush, any state:
  - target = jump ? jump_target : branch_target, with bits [1:0] forced to 0.
  - pc <= target
  - fd_instruction <= 0, fd_valid <= 0, fd_pc_plus4 <= 0
  - bubble_cnt <= FLUSH_BUBBLES-1
  - If FLUSH_BUBBLES=1, state -> RUN and the target is fetched on the next cycle. Otherwise state -> REDIRECT.
- REDIRECT:
  - pc holds at target; fd_* held as NOP with fd_valid=0; bubble_cnt decrements.
  - When bubble_cnt=0 at entry to a cycle, perform a normal fetch and go to RUN.
  - A stall in REDIRECT freezes bubble_cnt.
  - A new flush in REDIRECT reloads the target and bubble_cnt.
- Arithmetic: PC is 32-bit and wraps modulo 2^32. pc=32'hFFFF_FFFC gives next pc=0 and fd_pc_plus4=0.
- imem_addr is combinational from pc, never registered separately.

Optional Feature:
- Macro FETCH_PERF_CNT_EN. When defined, adds three outputs:
  - perf_fetch_cnt[31:0]: counts cycles where fd_valid is loaded with 1.
  - perf_stall_cnt[31:0]: counts stall cycles.
  - perf_flush_cnt[15:0]: counts flush events.
- All three counters wrap, reset to 0 on rst, and are not affected by flush.
- When not defined: the ports and counters are absent, with no other behavioural difference.

Decomposition:
- Shared package cpu_pipe_pkg:
  - NOP_INSTR = 32'h0
  - PC_WIDTH = 32
  - PC_INCR = 4
  - fetch_state_t enum {RUN, STALL, REDIRECT}
- One natural sub-module: fetch_pc_reg, containing the PC register, the +4 adder, target selection with alignment, and the hold mux.
- The state machine and IF/ID register stay in the top module.

Test Plan:
- Reset release, RESET_PC=0, imem returns addr+32'h100, no stall or flush for 3 cycles -> imem_addr 0,4,8; fd_instruction 32'h100 then 32'h104; fd_valid=1 from cycle 1.
- load_enable=0 for 3 cycles at pc=8 -> pc and fd_* frozen; stall_timeout stays 0 with STALL_LIMIT=16. Resume -> next fd_instruction=32'h108.
- flush=1, jump=0, branch_target=32'h203 -> pc=32'h200 next cycle, fd_valid=0, fd_instruction=0. One cycle later fd_instruction=32'h300.
- flush=1 and load_enable=0 in the same cycle, jump=1, jump_target=32'h40 -> redirect taken, pc=32'h40, no freeze.
- FLUSH_BUBBLES=3, flush, then stall during the second bubble -> exactly 3 NOP cycles excluding stalled cycles; a new flush in REDIRECT restarts the count with the new target.
- Hold load_enable=0 for 20 cycles with STALL_LIMIT=16 -> stall_timeout rises on stall cycle 16 and stays 1 after release; rst=1 mid-stall clears everything asynchronously.
